serial_chunk_adder: RTL and testbench

Multi-cycle, parametrised WIDTH-bit adder with carry-in that processes CHUNK bits per clock through a registered carry, trading latency for a narrow carry chain. It is the sequential successor of the single-bit half adder: it sits between an operand producer and a result consumer and uses valid/ready handshakes on both sides. It produces a WIDTH-bit sum, a carry-out and, optionally, a signed-overflow flag.

---
 rtl/serial_chunk_adder.sv | 169 ++++++++++++++++
 tb/tb_serial_chunk_adder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
//
// Multi-cycle WIDTH-bit adder with carry-in. Each clock it adds CHUNK bits,
// and a registered carry links one chunk to the next. The carry chain is
// only CHUNK+1 bits long, at the cost of NCHUNK = WIDTH/CHUNK cycles of
// latency. Operands arrive and results leave through valid/ready handshakes.
//
// Parameters
//   WIDTH  operand and sum width; must be an integer multiple of CHUNK
//   CHUNK  bits added per cycle, 1 <= CHUNK <= WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b and cin are valid
//   in_ready   block accepts operands this cycle (combinational on out_ready)
//   a, b       WIDTH-bit operands, unsigned or two's complement
//   cin        carry-in
//   out_valid  sum / cout (/ ovf) are valid
//   out_ready  consumer accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of the MSB
//   ovf        signed overflow (only with SERIAL_CHUNK_ADDER_OVF_EN defined)
//
// Optional feature: define SERIAL_CHUNK_ADDER_OVF_EN to add the ovf port and
// its register. Without it there is no ovf port and no related logic.

module serial_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_next;
    logic             cout_q;

    // {carry out, CHUNK-bit sum} of the chunk currently at the bottom of
    // the operand shift registers
    logic [CHUNK:0]   chunk_res;

    assign chunk_res = {1'b0, op_a[CHUNK-1:0]}
                     + {1'b0, op_b[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry};

    // The new chunk result enters the sum register at the MSB end. After
    // NCHUNK shifts the first chunk has moved down to bit 0.
    if (CHUNK == WIDTH) begin : g_full
        assign sum_next = chunk_res[CHUNK-1:0];
    end else begin : g_part
        assign sum_next = {chunk_res[CHUNK-1:0], sum_q[WIDTH-1:CHUNK]};
    end

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == LAST_CNT);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    logic ovf_q;
    logic msb_carry_in;

    // The carry into the chunk MSB follows from the sum bit: s = a ^ b ^ c_in
    assign msb_carry_in = chunk_res[CHUNK-1] ^ op_a[CHUNK-1] ^ op_b[CHUNK-1];
    assign ovf          = ovf_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = in_valid ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, per-chunk add and result load. Acceptance
    // and RUN never coincide because in_ready is low throughout RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> CHUNK;
            op_b  <= op_b >> CHUNK;
            sum_q <= sum_next;
            carry <= chunk_res[CHUNK];
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                cout_q <= chunk_res[CHUNK];
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
                ovf_q  <= msb_carry_in ^ chunk_res[CHUNK];
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Testbench for serial_chunk_adder. The main instance uses WIDTH=8, CHUNK=2.
// A second instance uses WIDTH=CHUNK=8. Results of the main instance go
// through a FIFO of expected values that is filled when operands are
// accepted and emptied when the DUT retires a result. ovf is checked only
// when SERIAL_CHUNK_ADDER_OVF_EN is defined.

module tb_serial_chunk_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [7:0] a, b, sum;

    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
    logic [7:0] a8, b8, sum8;

`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    logic       ovf, ovf8;
`endif

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present one operand set and wait (bounded) for acceptance. The
    // operands are scrambled right after acceptance.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input bit push);
        int   n;
        exp_t e;
        n = 0;
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(in_ready), 32'(1));
        if (in_ready && push) begin
            e.sum = es; e.cout = ec; e.ovf = eo;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'(0));
        @(posedge clk); #1;
    endtask

    // WIDTH=CHUNK=8 instance: one result one cycle after acceptance
    task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input logic [7:0] es, input logic ec, input logic eo);
        a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        chk("w8_in_ready", 32'(in_ready8), 32'(1));
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = ~ta; b8 = ~tb; cin8 = ~tc;
        @(negedge clk);
        chk("w8_valid_early", 32'(out_valid8), 32'(0));
        @(negedge clk);
        chk("w8_valid", 32'(out_valid8), 32'(1));
        chk("w8_sum", 32'(sum8), 32'(es));
        chk("w8_cout", 32'(cout8), 32'(ec));
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
        chk("w8_ovf", 32'(ovf8), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected ovf value");
`endif
        @(posedge clk); #1;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h55, 8'h2A, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[9] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

        in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0;
        in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; cin8 = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Scoreboard consumer: compares every retired result
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst_n && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected actual sum=%0h required no output", sum);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_sum", 32'(sum), 32'(e.sum));
                        chk("sb_cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
                        chk("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'(0));
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: busy for 4 cycles, result after the 4th RUN edge
        send(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lat_in_ready_run", 32'(in_ready), 32'(0));
            chk("lat_out_valid_run", 32'(out_valid), 32'(0));
        end
        @(negedge clk);
        chk("lat_out_valid", 32'(out_valid), 32'(1));
        drain();

        // Table vectors, back to back
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b1);
        end
        drain();

        // Random vectors against a reference addition
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            logic [8:0] t;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            t  = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            send(ra, rb, rc, t[7:0], t[8], (ra[7] == rb[7]) && (t[7] != ra[7]), 1'b1);
        end
        drain();

        // Backpressure, then retire and accept on the same edge
        out_ready = 1'b0;
        send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("bp_reach_done", 32'(out_valid), 32'(1));
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_sum", 32'(sum), 32'(8'h80));
            chk("bp_cout", 32'(cout), 32'(0));
            chk("bp_in_ready", 32'(in_ready), 32'(0));
            chk("bp_out_valid", 32'(out_valid), 32'(1));
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", 32'(in_ready), 32'(1));
        begin
            exp_t e;
            e.sum = 8'h47; e.cout = 1'b0; e.ovf = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'hEE; b = 8'hEE; cin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b2b_out_valid_run", 32'(out_valid), 32'(0));
        end
        @(negedge clk);
        chk("b2b_out_valid", 32'(out_valid), 32'(1));
        drain();

        // Reset two cycles after acceptance discards the operation
        send(8'hC3, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rr_out_valid", 32'(out_valid), 32'(0));
        chk("rr_in_ready", 32'(in_ready), 32'(1));
        chk("rr_sum", 32'(sum), 32'(0));
        chk("rr_cout", 32'(cout), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();

        // WIDTH = CHUNK = 8
        send8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        send8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        send8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

        // Reset while the CHUNK=WIDTH instance holds a result in DONE
        out_ready8 = 1'b0;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("w8_hold_valid", 32'(out_valid8), 32'(1));
        chk("w8_hold_sum", 32'(sum8), 32'(8'h00));
        chk("w8_hold_cout", 32'(cout8), 32'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("w8_rst_valid", 32'(out_valid8), 32'(0));
        chk("w8_rst_in_ready", 32'(in_ready8), 32'(1));
        chk("w8_rst_cout", 32'(cout8), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
